gb_reg_file: RTL

- SM83-style 8-bit general register file sitting directly upstream of the ALU.
- Supplies registered operand_A/operand_B to the ALU and accepts the ALU result back as a write-back.
- Holds the flag register F and supports 16-bit register-pair increment, decrement and load for HL+/HL-/16-bit moves.
- All state commits once per machine cycle, on the clk cycle in which a rising edge of phi is detected.

---
 rtl/gb_reg_file.sv | 112 +++++++++++
 1 files changed

// File: rtl/gb_reg_file.sv
// rtl/gb_reg_file.sv - SM83-style register file with flags, pair ops and phi-gated commit (option: GB_REG_FILE_BYPASS_EN)
module gb_reg_file #(
  parameter int DATA_WIDTH     = 8,
  parameter int REG_SEL_WIDTH  = 3,
  parameter int PAIR_SEL_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      phi,
  input  logic [REG_SEL_WIDTH-1:0]  rd_a_sel,
  input  logic [REG_SEL_WIDTH-1:0]  rd_b_sel,
  output logic [DATA_WIDTH-1:0]     operand_A,
  output logic [DATA_WIDTH-1:0]     operand_B,
  input  logic                      wr_en,
  input  logic [REG_SEL_WIDTH-1:0]  wr_sel,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [3:0]                flag_wr_en,
  input  logic [3:0]                flag_in,
  input  logic [1:0]                pair_op,
  input  logic [PAIR_SEL_WIDTH-1:0] pair_sel,
  input  logic [2*DATA_WIDTH-1:0]   pair_data,
  output logic [2*DATA_WIDTH-1:0]   pair_out,
  output logic [3:0]                flags,
  output logic                      commit
);

  localparam int NUM_REGS = 1 << REG_SEL_WIDTH;
  localparam logic [REG_SEL_WIDTH-1:0] F_IDX = REG_SEL_WIDTH'(6);
  localparam logic [2*DATA_WIDTH-1:0] PAIR_ONE = (2*DATA_WIDTH)'(1);

  localparam logic [1:0] PAIR_NONE = 2'd0;
  localparam logic [1:0] PAIR_INC  = 2'd1;
  localparam logic [1:0] PAIR_DEC  = 2'd2;

  logic [DATA_WIDTH-1:0]    regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]    regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0]    operand_a_q, operand_a_d;
  logic [DATA_WIDTH-1:0]    operand_b_q, operand_b_d;
  logic                     phi_q, phi_d;
  logic                     commit_q, commit_d;
  logic                     commit_int;
  logic [REG_SEL_WIDTH-1:0] pair_hi_idx, pair_lo_idx;
  logic [2*DATA_WIDTH-1:0]  pair_cur, pair_next;

  // Map the pair selector onto its high/low register indices (BC, DE, HL, AF).
  always_comb begin
    pair_hi_idx = REG_SEL_WIDTH'(7);
    pair_lo_idx = F_IDX;
    case (pair_sel)
      PAIR_SEL_WIDTH'(0): begin pair_hi_idx = REG_SEL_WIDTH'(0); pair_lo_idx = REG_SEL_WIDTH'(1); end
      PAIR_SEL_WIDTH'(1): begin pair_hi_idx = REG_SEL_WIDTH'(2); pair_lo_idx = REG_SEL_WIDTH'(3); end
      PAIR_SEL_WIDTH'(2): begin pair_hi_idx = REG_SEL_WIDTH'(4); pair_lo_idx = REG_SEL_WIDTH'(5); end
      default:            begin pair_hi_idx = REG_SEL_WIDTH'(7); pair_lo_idx = F_IDX;            end
    endcase
  end

  // Next state: byte write, then flag overrides, then pair op; F low nibble always cleared.
  always_comb begin
    commit_int = phi & ~phi_q;
    phi_d      = phi;
    commit_d   = commit_int;
    regs_d     = regs_q;
    pair_cur   = {regs_q[pair_hi_idx], regs_q[pair_lo_idx]};
    case (pair_op)
      PAIR_INC: pair_next = pair_cur + PAIR_ONE;
      PAIR_DEC: pair_next = pair_cur - PAIR_ONE;
      default:  pair_next = pair_data;
    endcase
    if (commit_int) begin
      if (wr_en) regs_d[wr_sel] = wr_data;
      for (int i = 0; i < 4; i++) begin
        if (flag_wr_en[i]) regs_d[F_IDX][DATA_WIDTH-4+i] = flag_in[i];
      end
      if (pair_op != PAIR_NONE) begin
        regs_d[pair_hi_idx] = pair_next[2*DATA_WIDTH-1:DATA_WIDTH];
        regs_d[pair_lo_idx] = pair_next[DATA_WIDTH-1:0];
      end
      regs_d[F_IDX][DATA_WIDTH-5:0] = '0;
    end
`ifdef GB_REG_FILE_BYPASS_EN
    operand_a_d = regs_d[rd_a_sel];
    operand_b_d = regs_d[rd_b_sel];
`else
    operand_a_d = regs_q[rd_a_sel];
    operand_b_d = regs_q[rd_b_sel];
`endif
  end

  // State registers; phi_q resets high so a held-high phi cannot commit at release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      operand_a_q <= '0;
      operand_b_q <= '0;
      phi_q       <= 1'b1;
      commit_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      operand_a_q <= operand_a_d;
      operand_b_q <= operand_b_d;
      phi_q       <= phi_d;
      commit_q    <= commit_d;
    end
  end

  assign operand_A = operand_a_q;
  assign operand_B = operand_b_q;
  assign commit    = commit_q;
  assign pair_out  = {regs_q[pair_hi_idx], regs_q[pair_lo_idx]};
  assign flags     = regs_q[F_IDX][DATA_WIDTH-1:DATA_WIDTH-4];

endmodule
